// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared constants for the quiz datapath: answer ROM, button width, debounce length.
package quiz_pkg;

  localparam int BOTAO_W         = 4;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int GABARITO_N      = 16;

  // One-hot correct answer for each round, indexed by the round counter.
  localparam logic [BOTAO_W-1:0] GABARITO [GABARITO_N] = '{
    4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0010
  };

endpackage

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - button synchroniser, optional debouncer (QUIZ_DEBOUNCE_EN) and press-edge detector.
module detector_jogada
  import quiz_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [BOTAO_W-1:0] botoes,
  output logic               jogada,
  output logic [BOTAO_W-1:0] botao
);

  logic [BOTAO_W-1:0] sync1_q, sync1_d;
  logic [BOTAO_W-1:0] sync2_q, sync2_d;
  logic [BOTAO_W-1:0] filtrado;
  logic               any_prev_q, any_prev_d;
  logic               jogada_q, jogada_d;

`ifdef QUIZ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [BOTAO_W-1:0] deb_q, deb_d;
  logic [BOTAO_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // cand tracks the value being timed; any change restarts the stability window.
  always_comb begin
    deb_d  = deb_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d  = '0;
      cand_d = sync2_q;
    end else if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_q  <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      deb_q  <= deb_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filtrado = deb_q;
`else
  assign filtrado = sync2_q;
`endif

  always_comb begin
    sync1_d    = botoes;
    sync2_d    = sync1_q;
    any_prev_d = |filtrado;
    jogada_d   = (|filtrado) & ~any_prev_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      any_prev_q <= 1'b0;
      jogada_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      any_prev_q <= any_prev_d;
      jogada_q   <= jogada_d;
    end
  end

  assign jogada = jogada_q;
  assign botao  = filtrado;

endmodule

// File: rtl/fluxo_dados_quiz.sv
// rtl/fluxo_dados_quiz.sv - quiz game datapath: round/entry/timer/score counters, R/M registers, status flags.
// Button debouncing is enabled by defining QUIZ_DEBOUNCE_EN.
module fluxo_dados_quiz
  import quiz_pkg::*;
#(
  parameter int N_RODADAS = 16,
  parameter int T_MOSTRA  = 1000,
  parameter int T_RESP_0  = 3000,
  parameter int T_RESP_1  = 1500,
  parameter int TMR_W     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         zeraR,
  input  logic                         zeraE,
  input  logic                         zeraS,
  input  logic                         zeraM,
  input  logic                         zeraTMR,
  input  logic                         zeraL,
  input  logic                         registraR,
  input  logic                         registraM,
  input  logic                         contaE,
  input  logic                         contaS,
  input  logic                         contaTMR,
  input  logic [BOTAO_W-1:0]           botoes,
  input  logic                         modo,
  output logic                         jogada,
  output logic                         igual,
  output logic                         timeout,
  output logic                         enderecoIgualSequencia,
  output logic                         fimE,
  output logic                         fimS,
  output logic                         fimTMR,
  output logic [$clog2(N_RODADAS)-1:0] db_rodada,
  output logic [BOTAO_W-1:0]           db_jogada,
  output logic [$clog2(N_RODADAS):0]   db_acertos
);

  localparam int S_W = $clog2(N_RODADAS);
  localparam int L_W = S_W + 1;

  localparam logic [S_W-1:0]   S_MAX      = S_W'(N_RODADAS - 1);
  localparam logic [L_W-1:0]   L_MAX      = L_W'(N_RODADAS);
  localparam logic [TMR_W-1:0] LIM_MOSTRA = TMR_W'(T_MOSTRA - 1);
  localparam logic [TMR_W-1:0] LIM_RESP_0 = TMR_W'(T_RESP_0 - 1);
  localparam logic [TMR_W-1:0] LIM_RESP_1 = TMR_W'(T_RESP_1 - 1);

  logic [S_W-1:0]     s_q, s_d;
  logic [S_W-1:0]     e_q, e_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [BOTAO_W-1:0] r_q, r_d;
  logic               m_q, m_d;
  logic [L_W-1:0]     l_q, l_d;
  logic [BOTAO_W-1:0] botao;

  detector_jogada u_detector (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .jogada (jogada),
    .botao  (botao)
  );

  assign igual = (r_q == GABARITO[s_q]);

  // Every clear outranks the count/load strobe of the same register.
  always_comb begin
    s_d   = s_q;
    e_d   = e_q;
    tmr_d = tmr_q;
    r_d   = r_q;
    m_d   = m_q;
    l_d   = l_q;

    if (zeraS)                        s_d = '0;
    else if (contaS && s_q != S_MAX)  s_d = s_q + 1'b1;

    if (zeraE)                        e_d = '0;
    else if (contaE)                  e_d = (e_q == S_MAX) ? '0 : e_q + 1'b1;

    if (zeraTMR)                      tmr_d = '0;
    else if (contaTMR && tmr_q != '1) tmr_d = tmr_q + 1'b1;

    if (zeraR)                        r_d = '0;
    else if (registraR)               r_d = botao;

    if (zeraM)                        m_d = 1'b0;
    else if (registraM)               m_d = modo;

    // Score follows the round being closed, even on the saturated last round.
    if (zeraL)                                   l_d = '0;
    else if (contaS && igual && l_q != L_MAX)    l_d = l_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q   <= '0;
      e_q   <= '0;
      tmr_q <= '0;
      r_q   <= '0;
      m_q   <= 1'b0;
      l_q   <= '0;
    end else begin
      s_q   <= s_d;
      e_q   <= e_d;
      tmr_q <= tmr_d;
      r_q   <= r_d;
      m_q   <= m_d;
      l_q   <= l_d;
    end
  end

  assign timeout                = tmr_q >= (m_q ? LIM_RESP_1 : LIM_RESP_0);
  assign enderecoIgualSequencia = (e_q == s_q);
  assign fimE                   = (e_q == S_MAX);
  assign fimS                   = (s_q == S_MAX);
  assign fimTMR                 = (tmr_q >= LIM_MOSTRA);
  assign db_rodada              = s_q;
  assign db_jogada              = r_q;
  assign db_acertos             = l_q;

endmodule

// File: tb/tb_fluxo_dados_quiz.sv
// tb/tb_fluxo_dados_quiz.sv - randomized and directed self-checking bench for fluxo_dados_quiz against a history-based model.
module tb_fluxo_dados_quiz;

  localparam int TB_N      = 16;
  localparam int TB_MOSTRA = 8;
  localparam int TB_RESP_0 = 12;
  localparam int TB_RESP_1 = 5;
  localparam int TB_TMR_W  = 5;
  localparam int TMR_SAT   = (1 << TB_TMR_W) - 1;
  localparam int MAXC      = 8192;
`ifdef QUIZ_DEBOUNCE_EN
  localparam int DEB = quiz_pkg::DEBOUNCE_CYCLES;
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  localparam logic [3:0] GAB [16] = '{
    4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0010
  };

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zeraR = 0, zeraE = 0, zeraS = 0, zeraM = 0, zeraTMR = 0, zeraL = 0;
  logic       registraR = 0, registraM = 0, contaE = 0, contaS = 0, contaTMR = 0;
  logic [3:0] botoes = '0;
  logic       modo = 0;
  logic       jogada, igual, timeout, enderecoIgualSequencia, fimE, fimS, fimTMR;
  logic [3:0] db_rodada;
  logic [3:0] db_jogada;
  logic [4:0] db_acertos;

  fluxo_dados_quiz #(
    .N_RODADAS (TB_N),
    .T_MOSTRA  (TB_MOSTRA),
    .T_RESP_0  (TB_RESP_0),
    .T_RESP_1  (TB_RESP_1),
    .TMR_W     (TB_TMR_W)
  ) dut (
    .clock (clock), .reset (reset),
    .zeraR (zeraR), .zeraE (zeraE), .zeraS (zeraS), .zeraM (zeraM),
    .zeraTMR (zeraTMR), .zeraL (zeraL),
    .registraR (registraR), .registraM (registraM),
    .contaE (contaE), .contaS (contaS), .contaTMR (contaTMR),
    .botoes (botoes), .modo (modo),
    .jogada (jogada), .igual (igual), .timeout (timeout),
    .enderecoIgualSequencia (enderecoIgualSequencia),
    .fimE (fimE), .fimS (fimS), .fimTMR (fimTMR),
    .db_rodada (db_rodada), .db_jogada (db_jogada), .db_acertos (db_acertos)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button path expressed as per-edge history, registers as plain integers.
  logic [3:0] raw_h  [MAXC];
  logic [3:0] filt_h [MAXC];
  int n = 0;
  int last_rst = 0;
  int s_m = 0, e_m = 0, tmr_m = 0, r_m = 0, m_m = 0, l_m = 0;
  int jog_m = 0;
  int r_new, igual_old;
  logic [3:0] v;
  bit stable;

  function automatic logic [3:0] raw_at(int k);
    if (k <= last_rst || k < 0) return 4'b0;
    return raw_h[k];
  endfunction

  function automatic logic [3:0] s2_at(int k);
    if (k <= last_rst) return 4'b0;
    return raw_at(k - 1);
  endfunction

  function automatic logic [3:0] filt_at(int k);
    if (k <= last_rst || k < 0) return 4'b0;
    return filt_h[k];
  endfunction

  always @(posedge clock or posedge reset) begin
    n = n + 1;
    if (reset) begin
      last_rst  = n;
      raw_h[n]  = '0;
      filt_h[n] = '0;
      s_m = 0; e_m = 0; tmr_m = 0; r_m = 0; m_m = 0; l_m = 0; jog_m = 0;
    end else begin
      raw_h[n] = botoes;
`ifdef QUIZ_DEBOUNCE_EN
      v = s2_at(n - 1);
      stable = 1'b1;
      for (int j = 1; j <= DEB; j++)
        if (s2_at(n - j) != v) stable = 1'b0;
      filt_h[n] = (stable && v != filt_at(n - 1)) ? v : filt_at(n - 1);
`else
      filt_h[n] = s2_at(n);
`endif
      jog_m = ((|filt_at(n - 1)) && !(|filt_at(n - 2))) ? 1 : 0;
      r_new = int'(filt_at(n - 1));
      igual_old = (r_m == int'(GAB[s_m])) ? 1 : 0;

      if (zeraL) l_m = 0;
      else if (contaS && igual_old == 1 && l_m < TB_N) l_m = l_m + 1;
      if (zeraS) s_m = 0;
      else if (contaS && s_m < TB_N - 1) s_m = s_m + 1;
      if (zeraE) e_m = 0;
      else if (contaE) e_m = (e_m + 1) % TB_N;
      if (zeraTMR) tmr_m = 0;
      else if (contaTMR && tmr_m < TMR_SAT) tmr_m = tmr_m + 1;
      if (zeraR) r_m = 0;
      else if (registraR) r_m = r_new;
      if (zeraM) m_m = 0;
      else if (registraM) m_m = int'(modo);
    end
  end

  always @(negedge clock) begin
    chk("rodada",  int'(db_rodada), s_m);
    chk("jogada_r", int'(db_jogada), r_m);
    chk("acertos", int'(db_acertos), l_m);
    chk("igual",   int'(igual), (r_m == int'(GAB[s_m])) ? 1 : 0);
    chk("timeout", int'(timeout), (tmr_m >= (m_m != 0 ? TB_RESP_1 - 1 : TB_RESP_0 - 1)) ? 1 : 0);
    chk("eq_seq",  int'(enderecoIgualSequencia), (e_m == s_m) ? 1 : 0);
    chk("fimE",    int'(fimE), (e_m == TB_N - 1) ? 1 : 0);
    chk("fimS",    int'(fimS), (s_m == TB_N - 1) ? 1 : 0);
    chk("fimTMR",  int'(fimTMR), (tmr_m >= TB_MOSTRA - 1) ? 1 : 0);
    chk("pulse",   int'(jogada), jog_m);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic count_pulses(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      step();
      if (jogada) cnt++;
    end
  endtask

  int pulses;
  int hold;

  initial begin
    @(negedge clock);
    chk("rst_S",   int'(db_rodada), 0);
    chk("rst_R",   int'(db_jogada), 0);
    chk("rst_L",   int'(db_acertos), 0);
    chk("rst_eq",  int'(enderecoIgualSequencia), 1);
    chk("rst_jog", int'(jogada), 0);
    chk("rst_fimS", int'(fimS), 0);
    chk("rst_igual", int'(igual), 0);
    #1 reset = 1'b0;
    step();

    // Single press held: exactly one pulse LAT clocks later, captured into R.
    botoes = 4'b0010;
    for (int i = 1; i <= LAT; i++) begin
      step();
      chk("press_lat", int'(jogada), (i == LAT) ? 1 : 0);
    end
    registraR = 1;
    step();
    registraR = 0;
    chk("press_R", int'(db_jogada), 2);
    chk("press_igual", int'(igual), 1);
    botoes = 4'b0110;
    count_pulses(8, pulses);
    chk("press_hold_one", pulses, 0);
    botoes = 4'b0000;
    repeat (LAT + 2) step();

    // Show timer.
    zeraTMR = 1; step(); zeraTMR = 0;
    contaTMR = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("fimTMR_cnt", int'(fimTMR), (i >= TB_MOSTRA - 1) ? 1 : 0);
    end
    repeat (40) step();
    chk("tmr_sat_timeout", int'(timeout), 1);

    // Answer windows for both modes.
    modo = 1; registraM = 1; zeraTMR = 1; step(); registraM = 0; zeraTMR = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("timeout_m1", int'(timeout), (i >= TB_RESP_1 - 1) ? 1 : 0);
    end
    modo = 0; registraM = 1; zeraTMR = 1; step(); registraM = 0; zeraTMR = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("timeout_m0", int'(timeout), (i >= TB_RESP_0 - 1) ? 1 : 0);
    end
    contaTMR = 0;

    // Full game with every answer correct.
    zeraS = 1; zeraL = 1; zeraR = 1; step(); zeraS = 0; zeraL = 0; zeraR = 0;
    for (int k = 0; k < TB_N; k++) begin
      botoes = 4'b0000;
      repeat (LAT + 1) step();
      botoes = GAB[k];
      repeat (LAT) step();
      registraR = 1; step(); registraR = 0;
      botoes = 4'b0000;
      contaS = 1; step(); contaS = 0;
    end
    chk("game_fimS", int'(fimS), 1);
    chk("game_S", int'(db_rodada), 15);
    chk("game_L", int'(db_acertos), 16);
    contaS = 1; step(); contaS = 0;
    chk("game_L_sat", int'(db_acertos), 16);

    // Entry counter wrap.
    zeraE = 1; step(); zeraE = 0;
    contaE = 1;
    repeat (15) step();
    chk("E_fim", int'(fimE), 1);
    step();
    chk("E_wrap", int'(fimE), 0);
    contaE = 0;

    // Reset mid-game with a button held.
    botoes = 4'b0100;
    repeat (2) step();
    reset = 1;
    #1;
    chk("mid_rst_S", int'(db_rodada), 0);
    chk("mid_rst_L", int'(db_acertos), 0);
    chk("mid_rst_jog", int'(jogada), 0);
    botoes = 4'b0000;
    step(); step();
    reset = 0;
    count_pulses(LAT + 4, pulses);
    chk("post_rst_none", pulses, 0);
    botoes = 4'b0001;
    count_pulses(LAT + 4, pulses);
    chk("repress_one", pulses, 1);
    botoes = 4'b0000;
    repeat (LAT + 2) step();
`ifdef QUIZ_DEBOUNCE_EN
    botoes = 4'b0100;
    step(); step();
    botoes = 4'b0000;
    count_pulses(LAT + 6, pulses);
    chk("glitch_none", pulses, 0);
`endif

    // Random phase against the model.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 249) == 0) reset = 1;
      zeraS     = ($urandom_range(0, 31) == 0);
      zeraE     = ($urandom_range(0, 15) == 0);
      zeraTMR   = ($urandom_range(0, 11) == 0);
      zeraR     = ($urandom_range(0, 19) == 0);
      zeraM     = ($urandom_range(0, 29) == 0);
      zeraL     = ($urandom_range(0, 39) == 0);
      contaS    = ($urandom_range(0, 5) == 0);
      contaE    = ($urandom_range(0, 2) == 0);
      contaTMR  = ($urandom_range(0, 1) == 0);
      registraR = ($urandom_range(0, 2) == 0);
      registraM = ($urandom_range(0, 9) == 0);
      modo      = $urandom_range(0, 1) != 0;
      if (hold == 0) begin
        botoes = ($urandom_range(0, 1) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(0, 3));
        hold = $urandom_range(1, 10);
      end
      hold--;
      step();
    end
    reset = 0;
    {zeraS, zeraE, zeraTMR, zeraR, zeraM, zeraL} = '0;
    {contaS, contaE, contaTMR, registraR, registraM} = '0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
